dm_responder: RTL and testbench

- Data-memory responder for the pipelined CPU's load/store stage.
- Serves one outstanding read or write request at a time over a valid/ready request channel, and returns read data or a write acknowledge over a valid/ready response channel.
- Holds a 4 KB word-addressed store with byte enables. A configurable wait-state count models slow memory, so the pipeline's stall logic can be exercised.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/dm_bank.sv | 33 +++
 rtl/dm_responder.sv | 120 ++++++++++++
 tb/tb_dm_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU memory-side definitions: responder FSM encoding and data-memory geometry.
// Pure constants/types; no timing or flow-control behaviour of its own.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  localparam int DM_DEPTH_LOG2 = 10;
  localparam int DM_WORDS      = 1 << DM_DEPTH_LOG2;

endpackage

// File: rtl/dm_bank.sv
// Byte-enabled word store, cleared on reset; writes and the registered read both happen on the same edge.
// Read data appears one edge after addr (read-before-write); no flow control, caller owns sequencing.
module dm_bank
  import cpu_pkg::*;
#(
  parameter int DEPTH_LOG2 = DM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      rdata <= mem[addr];
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding load/store, response LATENCY edges after acceptance.
// req_ready only in IDLE; response held stable in RESP until rsp_ready.
module dm_responder
  import cpu_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = DM_DEPTH_LOG2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_we
);

  localparam logic       ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  dm_state_t             state, state_n;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;

  logic                  accept;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  bank_we;
  logic [3:0]            bank_be;
  logic [DEPTH_LOG2-1:0] bank_addr;
  logic [31:0]           bank_wdata;
  logic [31:0]           bank_rdata;
  logic                  unused_addr_bits;

  assign accept           = (state == IDLE) && req_valid;
  assign req_idx          = req_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

  // The commit edge is the one entering RESP: straight from the request with no wait states,
  // otherwise from the latched copy on the last WAIT cycle.
  always_comb begin
    bank_we    = 1'b0;
    bank_be    = be_q;
    bank_wdata = wdata_q;
    bank_addr  = (state == IDLE) ? req_idx : addr_q;
    if (ZERO_LAT) begin
      if (accept) begin
        bank_we    = req_we;
        bank_be    = req_be;
        bank_wdata = req_wdata;
      end
    end else if (state == WAIT && cnt == 4'd0) begin
      bank_we = we_q;
    end
  end

  dm_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (bank_we),
    .be    (bank_be),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_we    = 1'b0;
    rsp_rdata = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = ZERO_LAT ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_n = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_we    = we_q;
        rsp_rdata = we_q ? 32'h0 : bank_rdata;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_idx;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: one instance with two wait states, one with none, checked against a word-array model.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_we    [2];

  int vecs = 0;
  int misc = 0;

  logic [31:0] model [2][1024];

  logic        nxt_we;
  logic [31:0] nxt_addr, nxt_wdata;
  logic [3:0]  nxt_be;

  always #5 clk = ~clk;

  dm_responder #(.LATENCY(2), .DEPTH_LOG2(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_we(rsp_we[0])
  );

  dm_responder #(.LATENCY(0), .DEPTH_LOG2(10)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_we(rsp_we[1])
  );

  function automatic int lat_of(int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) model[s][i] = 32'h0;
  endtask

  // Starts and ends on a falling edge. With present_next, the nxt_* request is
  // driven during the back-pressure window and must wait for the IDLE return.
  task automatic txn(int s, logic we, logic [31:0] addr, logic [31:0] wd,
                     logic [3:0] be, int hold, logic present_next);
    logic [31:0] exp;
    logic [31:0] held;
    int idx;
    int n;
    idx = int'(addr[11:2]);
    exp = we ? 32'h0 : model[s][idx];
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) model[s][idx][8*b +: 8] = wd[8*b +: 8];

    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wd;
    req_be[s]    = be;
    rsp_ready[s] = (hold == 0);
    check("req_ready_idle", 32'(req_ready[s]), 32'd1);

    @(posedge clk);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge clk);
      if (i == 1) req_valid[s] = 1'b0;
      if (rsp_valid[s]) n = i;
    end
    check("rsp_latency", 32'(n), 32'(lat_of(s) + 1));
    if (n == 0) begin
      rsp_ready[s] = 1'b1;
      return;
    end
    check("rsp_we", 32'(rsp_we[s]), 32'(we));
    check("rsp_rdata", rsp_rdata[s], exp);
    held = rsp_rdata[s];

    for (int h = 0; h < hold; h++) begin
      if (present_next) begin
        req_valid[s] = 1'b1;
        req_we[s]    = nxt_we;
        req_addr[s]  = nxt_addr;
        req_wdata[s] = nxt_wdata;
        req_be[s]    = nxt_be;
      end
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[s]), 32'd1);
      check("hold_rdata", rsp_rdata[s], held);
      check("hold_we", 32'(rsp_we[s]), 32'(we));
      check("hold_req_ready", 32'(req_ready[s]), 32'd0);
    end

    rsp_ready[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rsp_drop", 32'(rsp_valid[s]), 32'd0);
    check("idle_return", 32'(req_ready[s]), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int s;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0;   req_be[i] = '0;   rsp_ready[i] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();

    // Reset state on both instances
    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
      check("rst_rsp_we", 32'(rsp_we[i]), 32'd0);
    end

    // Load from cleared memory, then store/load round trip
    txn(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 1'b0);
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 1'b0);

    // Partial byte enables and an all-disabled store
    txn(0, 1'b1, 32'h0000_0080, 32'h1122_3344, 4'hF, 0, 1'b0);
    txn(0, 1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'b0101, 0, 1'b0);
    txn(0, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0);
    txn(0, 1'b0, 32'h0000_0083, 32'h0, 4'h0, 0, 1'b0);

    // Address wrap at 4 KB
    txn(0, 1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF, 0, 1'b0);
    txn(0, 1'b0, 32'h0000_0004, 32'h0, 4'hF, 0, 1'b0);

    // Back-pressure with a competing request held during the window
    nxt_we = 1'b1; nxt_addr = 32'h0000_0100; nxt_wdata = 32'h5555_AAAA; nxt_be = 4'hF;
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 5, 1'b1);
    txn(0, nxt_we, nxt_addr, nxt_wdata, nxt_be, 0, 1'b0);
    txn(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 1'b0);

    // Reset while a store sits in WAIT
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h0000_0020;
    req_wdata[0] = 32'hCAFE_F00D; req_be[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    check("midrst_req_ready", 32'(req_ready[0]), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    txn(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 0, 1'b0);

    // Zero wait states
    txn(1, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 0, 1'b0);
    txn(1, 1'b0, 32'h0000_0030, 32'h0, 4'hF, 2, 1'b0);
    txn(1, 1'b1, 32'h0000_0030, 32'h7700_0077, 4'b1001, 0, 1'b0);
    txn(1, 1'b0, 32'h0000_1030, 32'h0, 4'hF, 0, 1'b0);

    // Random mix on both instances over a small aliased address window
    for (int t = 0; t < 80; t++) begin
      s = int'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      txn(s, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end

endmodule
